// File: rtl/mem_pkg.sv
// Shared definitions for the memory bus controller: default address width,
// register-window addresses and the loader sequencer states.
package mem_pkg;

  localparam int AW_DEF = 20;

  localparam logic [AW_DEF-1:0] SYND    = 20'hFFFFF;
  localparam logic [AW_DEF-1:0] ALATCH  = 20'hFFFFE;
  localparam logic [AW_DEF-1:0] ECCMODE = 20'hFFFFD;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_WAIT   = 2'd1,
    LD_ACCESS = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_t;

endpackage

// File: rtl/mem_regs.sv
// Register window at the top three word addresses: syndrome, address latch
// and the ECC mode register.
module mem_regs
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] laddr,
  input  logic          wr,
  input  logic [1:0]    wdata,
  output logic          hit,
  output logic [63:0]   rdata
);

  logic [AW-1:0] addr_inv;
  logic          sel_synd;
  logic          sel_alatch;
  logic          sel_mode;
  logic [1:0]    mode;

  // Window addresses are counted down from all-ones, so match on the
  // inverted address; this keeps the decode correct for any AW.
  assign addr_inv   = ~addr;
  assign sel_synd   = (addr_inv == AW'(~SYND));
  assign sel_alatch = (addr_inv == AW'(~ALATCH));
  assign sel_mode   = (addr_inv == AW'(~ECCMODE));
  assign hit        = sel_synd | sel_alatch | sel_mode;

  always_comb begin
    rdata = '0;
    if (sel_alatch)
      rdata = 64'(laddr);
    else if (sel_mode)
      rdata = 64'(mode);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mode <= '0;
    else if (wr && sel_mode)
      mode <= wdata;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-RAM bus controller with a low-priority loader port that borrows
// RAM cycles whenever the CPU is not reading or writing.
module mem_bus_ctrl
  import mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int STARVE = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   o_ad,
  input  logic [7:0]    o_tag,
  input  logic          o_astb,
  input  logic          o_atomic,
  input  logic          o_rd,
  input  logic          o_wr,
  output logic [63:0]   i_data,
  output logic [7:0]    i_tag,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [63:0]   ld_wdata,
  input  logic [7:0]    ld_wtag,
  output logic          ld_ack,
  output logic [63:0]   ld_rdata,
  output logic [7:0]    ld_rtag,
  output logic          ld_starve,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic [63:0]   ram_wdata,
  output logic [7:0]    ram_wtag,
  input  logic [63:0]   ram_q,
  input  logic [7:0]    ram_qtag
);

  localparam int CW = $clog2(STARVE + 2);

  logic [AW-1:0] waddr, laddr;
  logic          win_hit;
  logic [63:0]   win_rdata;
  logic          cpu_wr, cpu_rd, cpu_ram_wr, cpu_ram_rd;
  logic          rd_ram_q;
  logic [63:0]   data_hold, ld_data_hold;
  logic [7:0]    tag_hold, ld_tag_hold;
  ld_state_t     ld_state, ld_state_nxt;
  logic [CW-1:0] wait_cnt;

  assign cpu_wr     = o_wr & ~o_astb;
  assign cpu_rd     = o_rd & ~o_wr & ~o_astb;
  assign cpu_ram_wr = cpu_wr & ~win_hit;
  assign cpu_ram_rd = cpu_rd & ~win_hit;

  mem_regs #(.AW(AW)) u_regs (
    .clk   (clk),
    .reset (reset),
    .addr  (waddr),
    .laddr (laddr),
    .wr    (cpu_wr),
    .wdata (o_ad[1:0]),
    .hit   (win_hit),
    .rdata (win_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr <= '0;
      laddr <= '0;
    end else if (o_astb) begin
      waddr <= o_ad[AW-1:0];
      laddr <= waddr;
    end else if ((cpu_ram_wr || cpu_ram_rd) && !o_atomic) begin
      waddr <= waddr + AW'(1);
    end
  end

  // CPU always wins the RAM; the loader only drives it in ACCESS.
  always_comb begin
    ram_addr  = waddr;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = o_ad;
    ram_wtag  = o_tag;
    if (cpu_ram_wr) begin
      ram_we = 1'b1;
      if (o_atomic)
        ram_wdata[55] = 1'b1;
    end else if (cpu_ram_rd) begin
      ram_re = 1'b1;
    end else if (ld_state == LD_ACCESS) begin
      ram_addr  = ld_addr;
      ram_we    = ld_we;
      ram_re    = ~ld_we;
      ram_wdata = ld_wdata;
      ram_wtag  = ld_wtag;
    end
    if (reset) begin
      ram_re = 1'b0;
      ram_we = 1'b0;
    end
  end

  // Read data is shown straight from the RAM in the cycle after the read,
  // then held in a register until the next CPU read.
  assign i_data = rd_ram_q ? ram_q : data_hold;
  assign i_tag  = rd_ram_q ? ram_qtag : tag_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ram_q  <= 1'b0;
      data_hold <= '0;
      tag_hold  <= '0;
    end else begin
      rd_ram_q <= cpu_ram_rd;
      if (cpu_rd && win_hit) begin
        data_hold <= win_rdata;
        tag_hold  <= '0;
      end else begin
        data_hold <= i_data;
        tag_hold  <= i_tag;
      end
    end
  end

  always_comb begin
    ld_state_nxt = ld_state;
    case (ld_state)
      LD_IDLE:   if (ld_req) ld_state_nxt = (!o_rd && !o_wr) ? LD_ACCESS : LD_WAIT;
      LD_WAIT:   if (!o_rd && !o_wr) ld_state_nxt = LD_ACCESS;
      LD_ACCESS: ld_state_nxt = LD_DONE;
      default:   ld_state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state <= LD_IDLE;
      wait_cnt <= '0;
    end else begin
      ld_state <= ld_state_nxt;
      if (ld_state_nxt == LD_ACCESS)
        wait_cnt <= '0;
      else if (ld_state == LD_WAIT && wait_cnt != CW'(STARVE))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign ld_starve = (wait_cnt >= CW'(STARVE));
  assign ld_ack    = (ld_state == LD_DONE);
  assign ld_rdata  = (ld_ack && !ld_we) ? ram_q : ld_data_hold;
  assign ld_rtag   = (ld_ack && !ld_we) ? ram_qtag : ld_tag_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_data_hold <= '0;
      ld_tag_hold  <= '0;
    end else begin
      ld_data_hold <= ld_rdata;
      ld_tag_hold  <= ld_rtag;
    end
  end

endmodule
